regfile_arbiter: RTL
====================

Name: regfile_arbiter

Overview:
Two-client arbiter and sequencer for the shared 4-entry x 8-bit register file, which has one write port and one read port.
Each cycle it grants at most one client access to the file, chosen by round-robin.
It drives the file's write and read ports and returns registered read data to the client that issued the read.
A client can lock the file for an atomic read-modify-write, with a bounded hold time so the other client cannot starve.

Parameters:
DATA_W, 8, data width; matches the register file word.
ADDR_W, 2, address width; 4 entries.
LOCK_MAX, 4, maximum consecutive locked grants to one client before a forced release (range 1..15).

Ports:
clk  input  1  clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset.
a_req  input  1  client A access request.
a_we  input  1  client A: 1 = write, 0 = read.
a_lock  input  1  client A requests to keep ownership after this access.
a_addr  input  ADDR_W  client A address.
a_wdata  input  DATA_W  client A write data.
a_gnt  output  1  client A access accepted this cycle.
a_rvalid  output  1  client A read data valid (one-cycle pulse).
a_rdata  output  DATA_W  client A read data.
a_lock_lost  output  1  client A lock forcibly released (one-cycle pulse).
b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata, b_lock_lost: same as the A ports, for client B.
rf_write_enable  output  1  register file write enable.
rf_write_address  output  ADDR_W  register file write address.
rf_write_data  output  DATA_W  register file write data.
rf_read_address  output  ADDR_W  register file read address.
rf_read_data  input  DATA_W  register file combinational read data.

Behaviour:
- Reset (reset=0, async):
  - owner=NONE, last_served=B (A has priority first), hold_cnt=0.
  - a/b_rvalid=0, a/b_rdata=0, a/b_lock_lost=0.
- Handshake:
  - Client holds req, we, lock, addr, wdata stable until it sees gnt=1 in the same cycle.
  - An access completes on the clock edge where gnt=1.
  - gnt is combinational from req and the arbiter state; it is never asserted without req.
- Arbitration when owner=NONE:
  - Only one client requests: that client is granted.
  - Both request: the client that is not last_served is granted.
  - last_served updates to the granted client at the edge.
- Arbitration when owner=X:
  - If X req=1: only X is granted; the other client waits, gnt=0.
  - If X req=0: the lock releases combinationally and normal arbitration applies in that cycle; owner becomes NONE at the edge unless a new lock is taken.
- Port drive:
  - rf_write_enable = granted & we.
  - rf_write_address, rf_write_data, rf_read_address come from the granted client.
  - All rf outputs are 0 when no client is granted; the register file is never written without a grant.
- Reads:
  - On the grant edge, rf_read_data is captured into the granted client's rdata.
  - rvalid=1 for exactly the next cycle.
  - rdata holds its value until that client's next read.
  - A write granted at edge N followed by a read of the same address granted at edge N+1 returns the new data.
- Lock FSM (owner: NONE, A, B):
  - A grant with lock=1 sets owner to the granted client and increments hold_cnt.
  - A grant with lock=0 sets owner=NONE and hold_cnt=0.
  - If hold_cnt reaches LOCK_MAX on a grant:
    - owner=NONE and hold_cnt=0 at that edge, regardless of lock;
    - the holder's lock_lost pulses for the next cycle;
    - last_served=holder, so the other client wins the next contention.
  - Non-granted cycles leave hold_cnt unchanged while owner holds with req=1.
- Reset mid-lock or mid-read: all state returns to reset values; a pending rvalid is dropped.

Test Plan:
- Write/read, A only: A writes 0x5A to addr 2, then reads addr 2 -> a_gnt each cycle; rf_write_enable=1 with address 2, data 0x5A; a_rvalid pulses one cycle after the read grant with a_rdata=0x5A.
- Contention: A and B request every cycle from reset, neither locking -> grants alternate A, B, A, B; rf_write_enable never high without a gnt.
- Atomic RMW: A reads addr 1 with lock=1, then writes addr 1 with lock=0 while B requests continuously -> B gnt=0 for both A accesses, B granted in the cycle after A's write.
- Forced release: A holds lock=1 with req=1 for 6 cycles, LOCK_MAX=4, B requesting -> A granted 4 times; a_lock_lost pulses; B granted next; A regains access after B.
- Async reset mid-lock: assert reset=0 between clock edges while owner=A -> owner=NONE, rvalid/rdata/lock_lost cleared immediately; after release, simultaneous requests grant A first.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Two-client round-robin arbiter and sequencer for a shared 4 x 8 register file.
// Grants at most one access per cycle, drives the file's write/read ports, returns
// registered read data to the issuing client and supports a bounded atomic lock.
module regfile_arbiter #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    output logic              a_lock_lost,

    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              b_lock_lost,

    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_address,
    output logic [DATA_W-1:0] rf_write_data,
    output logic [ADDR_W-1:0] rf_read_address,
    input  logic [DATA_W-1:0] rf_read_data
);

    localparam logic [3:0] LockMax = 4'(LOCK_MAX);

    typedef enum logic [1:0] {StNone, StOwnA, StOwnB} owner_e;

    owner_e            owner_q, owner_d;
    logic              last_b_q, last_b_d;   // 1: B was served last, so A wins a tie
    logic [3:0]        hold_q, hold_d;
    logic              a_rvalid_q, a_rvalid_d;
    logic              b_rvalid_q, b_rvalid_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic              a_lost_q, a_lost_d;
    logic              b_lost_q, b_lost_d;

    logic              any_gnt;
    logic              sel_we;
    logic              sel_lock;
    logic [3:0]        cnt_inc;

    // Arbitration: an owner that still requests is exclusive; otherwise round-robin.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (owner_q == StOwnA && a_req) begin
            a_gnt = 1'b1;
        end else if (owner_q == StOwnB && b_req) begin
            b_gnt = 1'b1;
        end else if (a_req && b_req) begin
            if (last_b_q) begin
                a_gnt = 1'b1;
            end else begin
                b_gnt = 1'b1;
            end
        end else if (a_req) begin
            a_gnt = 1'b1;
        end else if (b_req) begin
            b_gnt = 1'b1;
        end
    end

    // Register file port drive from the granted client; all zero when idle.
    always_comb begin
        any_gnt          = a_gnt | b_gnt;
        sel_we           = 1'b0;
        sel_lock         = 1'b0;
        rf_write_enable  = 1'b0;
        rf_write_address = '0;
        rf_write_data    = '0;
        rf_read_address  = '0;
        if (a_gnt) begin
            sel_we           = a_we;
            sel_lock         = a_lock;
            rf_write_enable  = a_we;
            rf_write_address = a_addr;
            rf_write_data    = a_wdata;
            rf_read_address  = a_addr;
        end else if (b_gnt) begin
            sel_we           = b_we;
            sel_lock         = b_lock;
            rf_write_enable  = b_we;
            rf_write_address = b_addr;
            rf_write_data    = b_wdata;
            rf_read_address  = b_addr;
        end
    end

    // Next state: lock ownership, hold counter, round-robin pointer and read return.
    always_comb begin
        owner_d    = owner_q;
        last_b_d   = last_b_q;
        hold_d     = hold_q;
        a_lost_d   = 1'b0;
        b_lost_d   = 1'b0;
        cnt_inc    = 4'd1;
        a_rvalid_d = a_gnt & ~a_we;
        b_rvalid_d = b_gnt & ~b_we;
        a_rdata_d  = (a_gnt && !a_we) ? rf_read_data : a_rdata_q;
        b_rdata_d  = (b_gnt && !b_we) ? rf_read_data : b_rdata_q;

        if (any_gnt) begin
            last_b_d = b_gnt;
            if (sel_lock) begin
                // A change of owner restarts the count at this grant.
                if ((owner_q == StOwnA && a_gnt) || (owner_q == StOwnB && b_gnt)) begin
                    cnt_inc = hold_q + 4'd1;
                end
                if (cnt_inc >= LockMax) begin
                    owner_d  = StNone;
                    hold_d   = 4'd0;
                    a_lost_d = a_gnt;
                    b_lost_d = b_gnt;
                end else begin
                    owner_d = a_gnt ? StOwnA : StOwnB;
                    hold_d  = cnt_inc;
                end
            end else begin
                owner_d = StNone;
                hold_d  = 4'd0;
            end
        end else if (owner_q != StNone) begin
            // Owner dropped its request and nobody else took the file.
            owner_d = StNone;
            hold_d  = 4'd0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q    <= StNone;
            last_b_q   <= 1'b1;
            hold_q     <= 4'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
            a_lost_q   <= 1'b0;
            b_lost_q   <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            last_b_q   <= last_b_d;
            hold_q     <= hold_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
            a_rdata_q  <= a_rdata_d;
            b_rdata_q  <= b_rdata_d;
            a_lost_q   <= a_lost_d;
            b_lost_q   <= b_lost_d;
        end
    end

    assign a_rvalid    = a_rvalid_q;
    assign b_rvalid    = b_rvalid_q;
    assign a_rdata     = a_rdata_q;
    assign b_rdata     = b_rdata_q;
    assign a_lock_lost = a_lost_q;
    assign b_lock_lost = b_lost_q;

endmodule
